xmem_to_bram_pipe: RTL and testbench

Pipelined bridge from the narrow xmem request/response interface to one wide single-port BRAM. It accepts one request per cycle, with no idle cycles between back-to-back reads and writes. Each narrow access is steered onto its byte lane of the wide BRAM word. Every response returns in order at a fixed latency, and out-of-range or misaligned accesses are answered with an error and never reach the BRAM. It sits between a core-side xmem master and a BRAM macro, as the successor to the single-outstanding bridge.

---
 rtl/xmem_to_bram_pkg.sv | 36 +++
 rtl/xmem_rsp_pipe.sv | 26 ++
 rtl/xmem_to_bram_pipe.sv | 122 ++++++++++++
 tb/tb_xmem_to_bram_pipe.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/xmem_to_bram_pkg.sv
// Shared types and helpers for the xmem-to-BRAM bridge family.
// The tracking entry carries a lane field sized for the widest supported width ratio.
package xmem_to_bram_pkg;

    localparam int unsigned MaxLaneW = 8;
    localparam int unsigned MaxDataW = 1024;

    typedef logic [MaxLaneW-1:0] lane_t;

    typedef struct packed {
        logic  valid;
        logic  we;
        logic  err;
        lane_t lane;
    } track_t;

    // Narrow-word index inside the wide BRAM word; a ratio of 1 masks it to 0.
    function automatic lane_t lane_of(input logic [63:0] addr, input int unsigned xb_lg,
                                      input int unsigned ratio);
        logic [63:0] sh;
        sh = addr >> xb_lg;
        return lane_t'(sh) & lane_t'(ratio - 1);
    endfunction

    function automatic logic [MaxDataW-1:0] replicate(input logic [MaxDataW-1:0] wdata,
                                                      input int unsigned xw,
                                                      input int unsigned ratio);
        logic [MaxDataW-1:0] r;
        r = '0;
        for (int i = 0; i < MaxDataW; i++) begin
            if (i < xw * ratio) r[i] = wdata[i % xw];
        end
        return r;
    endfunction

endpackage

// File: rtl/xmem_rsp_pipe.sv
// Fixed-depth delay line of tracking entries; reset discards everything in flight.
module xmem_rsp_pipe
    import xmem_to_bram_pkg::*;
#(
    parameter int unsigned DEPTH = 3
) (
    input  logic   clk_i,
    input  logic   rst_i,
    input  track_t in_i,
    output track_t out_o
);

    track_t stage_q [DEPTH];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
        end else begin
            stage_q[0] <= in_i;
            for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
        end
    end

    assign out_o = stage_q[DEPTH-1];

endmodule

// File: rtl/xmem_to_bram_pipe.sv
// Fully pipelined xmem to wide single-port BRAM bridge: one request per cycle,
// in-order responses at a fixed latency of BRAM_READ_LATENCY + 1.
module xmem_to_bram_pipe
    import xmem_to_bram_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH        = 32,
    parameter int unsigned DATA_WIDTH        = 128,
    parameter int unsigned XADDR_WIDTH       = 32,
    parameter int unsigned XDATA_WIDTH       = 32,
    parameter int unsigned BRAM_READ_LATENCY = 2,
    parameter int unsigned BRAM_DEPTH        = 1024
) (
    input  logic                     aclk,
    input  logic                     areset,
    input  logic                     xmem_req,
    input  logic [XADDR_WIDTH-1:0]   xmem_addr,
    input  logic                     xmem_we,
    input  logic [XDATA_WIDTH-1:0]   xmem_wdata,
    input  logic [XDATA_WIDTH/8-1:0] xmem_be,
    output logic                     xmem_gnt,
    output logic                     xmem_rsp_valid,
    output logic [XDATA_WIDTH-1:0]   xmem_rsp_rdata,
    output logic                     xmem_rsp_error,
    output logic [ADDR_WIDTH-1:0]    bram_addra,
    output logic [DATA_WIDTH-1:0]    bram_dina,
    input  logic [DATA_WIDTH-1:0]    bram_douta,
    output logic                     bram_ena,
    output logic [DATA_WIDTH/8-1:0]  bram_wea
);

    localparam int unsigned XB    = XDATA_WIDTH / 8;
    localparam int unsigned WB    = DATA_WIDTH / 8;
    localparam int unsigned RATIO = DATA_WIDTH / XDATA_WIDTH;
    localparam int unsigned XbLg  = $clog2(XB);
    localparam int unsigned WbLg  = $clog2(WB);
    localparam int unsigned Lat   = BRAM_READ_LATENCY + 1;

    logic                   accept;
    logic                   err;
    logic [XADDR_WIDTH-1:0] word;
    lane_t                  lane;
    track_t                 trk_in;
    track_t                 trk_out;

    logic                  ena_d,  ena_q;
    logic [ADDR_WIDTH-1:0] addr_d, addr_q;
    logic [DATA_WIDTH-1:0] dina_d, dina_q;
    logic [WB-1:0]         wea_d,  wea_q;

    assign xmem_gnt = xmem_req && !areset;
    assign accept   = xmem_gnt;
    assign word     = xmem_addr >> WbLg;
    assign lane     = lane_of(64'(xmem_addr), XbLg, RATIO);
    assign err      = ((xmem_addr & XADDR_WIDTH'(XB - 1)) != '0) ||
                      (64'(word) >= 64'(BRAM_DEPTH));

    always_comb begin
        ena_d  = accept && !err;
        addr_d = addr_q;
        dina_d = dina_q;
        wea_d  = '0;
        if (ena_d) begin
            addr_d = ADDR_WIDTH'(word);
            if (xmem_we) begin
                dina_d = DATA_WIDTH'(replicate(MaxDataW'(xmem_wdata), XDATA_WIDTH, RATIO));
                wea_d  = WB'(xmem_be) << (lane * XB);
            end
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            ena_q  <= 1'b0;
            addr_q <= '0;
            dina_q <= '0;
            wea_q  <= '0;
        end else begin
            ena_q  <= ena_d;
            addr_q <= addr_d;
            dina_q <= dina_d;
            wea_q  <= wea_d;
        end
    end

    assign bram_ena   = ena_q;
    assign bram_addra = addr_q;
    assign bram_dina  = dina_q;
    assign bram_wea   = wea_q;

    // Idle cycles push an all-zero entry so valid bubbles travel with the data.
    always_comb begin
        trk_in       = '0;
        trk_in.valid = accept;
        trk_in.we    = accept && xmem_we;
        trk_in.err   = accept && err;
        trk_in.lane  = accept ? lane : '0;
    end

    xmem_rsp_pipe #(
        .DEPTH (Lat)
    ) u_rsp_pipe (
        .clk_i (aclk),
        .rst_i (areset),
        .in_i  (trk_in),
        .out_o (trk_out)
    );

    always_comb begin
        xmem_rsp_rdata = '0;
        if (trk_out.valid && !trk_out.we && !trk_out.err) begin
            for (int i = 0; i < RATIO; i++) begin
                if (trk_out.lane == lane_t'(i)) begin
                    xmem_rsp_rdata = bram_douta[i*XDATA_WIDTH +: XDATA_WIDTH];
                end
            end
        end
    end

    assign xmem_rsp_valid = trk_out.valid;
    assign xmem_rsp_error = trk_out.valid && trk_out.err;

endmodule

// File: tb/tb_xmem_to_bram_pipe.sv
// Directed bench for xmem_to_bram_pipe with a behavioural 2-cycle BRAM model.
module tb_xmem_to_bram_pipe;

    localparam int L = 3;

    logic         aclk = 1'b0;
    logic         areset;
    logic         xmem_req;
    logic [31:0]  xmem_addr;
    logic         xmem_we;
    logic [31:0]  xmem_wdata;
    logic [3:0]   xmem_be;
    logic         xmem_gnt;
    logic         xmem_rsp_valid;
    logic [31:0]  xmem_rsp_rdata;
    logic         xmem_rsp_error;
    logic [31:0]  bram_addra;
    logic [127:0] bram_dina;
    logic [127:0] bram_douta;
    logic         bram_ena;
    logic [15:0]  bram_wea;

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;

    logic        exp_ena [256];
    logic [15:0] exp_wea [256];
    logic        exp_v   [256];
    logic        exp_err [256];
    logic [31:0] exp_rd  [256];

    logic [127:0] mem [1024];
    logic [127:0] rd_s1, rd_s2;

    always #5 aclk = ~aclk;

    xmem_to_bram_pipe dut (
        .aclk           (aclk),
        .areset         (areset),
        .xmem_req       (xmem_req),
        .xmem_addr      (xmem_addr),
        .xmem_we        (xmem_we),
        .xmem_wdata     (xmem_wdata),
        .xmem_be        (xmem_be),
        .xmem_gnt       (xmem_gnt),
        .xmem_rsp_valid (xmem_rsp_valid),
        .xmem_rsp_rdata (xmem_rsp_rdata),
        .xmem_rsp_error (xmem_rsp_error),
        .bram_addra     (bram_addra),
        .bram_dina      (bram_dina),
        .bram_douta     (bram_douta),
        .bram_ena       (bram_ena),
        .bram_wea       (bram_wea)
    );

    always @(posedge aclk) begin
        if (bram_ena) begin
            for (int b = 0; b < 16; b++) begin
                if (bram_wea[b]) mem[bram_addra[9:0]][8*b +: 8] <= bram_dina[8*b +: 8];
            end
            rd_s1 <= mem[bram_addra[9:0]];
        end
        rd_s2 <= rd_s1;
    end
    assign bram_douta = rd_s2;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s (cycle %0d): observed %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge aclk);
        chk("gnt", 128'(xmem_gnt), 128'(xmem_req && !areset));
        chk("bram_ena", 128'(bram_ena), 128'(exp_ena[cyc]));
        chk("bram_wea", 128'(bram_wea), 128'(exp_wea[cyc]));
        chk("rsp_valid", 128'(xmem_rsp_valid), 128'(exp_v[cyc]));
        if (exp_v[cyc]) begin
            chk("rsp_error", 128'(xmem_rsp_error), 128'(exp_err[cyc]));
            chk("rsp_rdata", 128'(xmem_rsp_rdata), 128'(exp_rd[cyc]));
        end
        @(posedge aclk);
        #1;
        cyc++;
    endtask

    task automatic req(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [3:0] be, input logic ena, input logic [15:0] wea,
                       input logic err, input logic [31:0] rd);
        xmem_req   = 1'b1;
        xmem_we    = we;
        xmem_addr  = addr;
        xmem_wdata = wd;
        xmem_be    = be;
        exp_ena[cyc+1] = ena;
        exp_wea[cyc+1] = wea;
        exp_v[cyc+L]   = 1'b1;
        exp_err[cyc+L] = err;
        exp_rd[cyc+L]  = rd;
        tick();
    endtask

    task automatic idle();
        xmem_req = 1'b0;
        xmem_we  = 1'b0;
        tick();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " gnt"}, 128'(xmem_gnt), 128'(0));
        chk({tag, " ena"}, 128'(bram_ena), 128'(0));
        chk({tag, " wea"}, 128'(bram_wea), 128'(0));
        chk({tag, " addra"}, 128'(bram_addra), 128'(0));
        chk({tag, " dina"}, bram_dina, 128'(0));
        chk({tag, " rsp_valid"}, 128'(xmem_rsp_valid), 128'(0));
        chk({tag, " rsp_error"}, 128'(xmem_rsp_error), 128'(0));
        chk({tag, " rsp_rdata"}, 128'(xmem_rsp_rdata), 128'(0));
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        for (int i = 0; i < 256; i++) begin
            exp_ena[i] = 1'b0; exp_wea[i] = '0; exp_v[i] = 1'b0;
            exp_err[i] = 1'b0; exp_rd[i] = '0;
        end
        rd_s1 = '0;
        rd_s2 = '0;
        areset     = 1'b1;
        xmem_req   = 1'b1;
        xmem_addr  = '0;
        xmem_we    = 1'b0;
        xmem_wdata = '0;
        xmem_be    = '0;
        #1;
        chk_all_zero("reset");
        xmem_req = 1'b0;
        repeat (2) @(posedge aclk);
        #1;
        areset = 1'b0;
        cyc = 0;

        // Back-to-back lane writes, then back-to-back reads of the same word.
        req(1'b1, 32'h0, 32'h01234567, 4'hF, 1'b1, 16'h000F, 1'b0, 32'h0);
        req(1'b1, 32'h4, 32'h89abcdef, 4'hF, 1'b1, 16'h00F0, 1'b0, 32'h0);
        req(1'b1, 32'h8, 32'hfedcba98, 4'hF, 1'b1, 16'h0F00, 1'b0, 32'h0);
        req(1'b1, 32'hC, 32'h76543210, 4'hF, 1'b1, 16'hF000, 1'b0, 32'h0);
        req(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 16'h0, 1'b0, 32'h01234567);
        req(1'b0, 32'h4, 32'h0, 4'h0, 1'b1, 16'h0, 1'b0, 32'h89abcdef);
        req(1'b0, 32'h8, 32'h0, 4'h0, 1'b1, 16'h0, 1'b0, 32'hfedcba98);
        req(1'b0, 32'hC, 32'h0, 4'h0, 1'b1, 16'h0, 1'b0, 32'h76543210);

        // Read-after-write and partial byte write.
        req(1'b1, 32'h10, 32'ha5a5a5a5, 4'hF, 1'b1, 16'h000F, 1'b0, 32'h0);
        req(1'b0, 32'h10, 32'h0, 4'h0, 1'b1, 16'h0, 1'b0, 32'ha5a5a5a5);
        req(1'b1, 32'h14, 32'hffffffff, 4'hF, 1'b1, 16'h00F0, 1'b0, 32'h0);
        req(1'b1, 32'h14, 32'h00003c00, 4'h2, 1'b1, 16'h0020, 1'b0, 32'h0);
        req(1'b0, 32'h14, 32'h0, 4'h0, 1'b1, 16'h0, 1'b0, 32'hffff3cff);

        // Misaligned and out-of-range reads never reach the BRAM.
        req(1'b0, 32'h2, 32'h0, 4'h0, 1'b0, 16'h0, 1'b1, 32'h0);
        req(1'b0, 32'h4000, 32'h0, 4'h0, 1'b0, 16'h0, 1'b1, 32'h0);
        repeat (L + 1) idle();

        // Reset with two reads in flight.
        req(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 16'h0, 1'b0, 32'h01234567);
        req(1'b0, 32'h4, 32'h0, 4'h0, 1'b1, 16'h0, 1'b0, 32'h89abcdef);
        for (int i = 0; i <= L + 1; i++) begin
            exp_ena[cyc+i] = 1'b0;
            exp_v[cyc+i]   = 1'b0;
        end
        xmem_req = 1'b1;
        areset   = 1'b1;
        #1;
        chk_all_zero("mid_reset");
        tick();
        areset   = 1'b0;
        repeat (L + 1) idle();
        req(1'b0, 32'h8, 32'h0, 4'h0, 1'b1, 16'h0, 1'b0, 32'hfedcba98);
        repeat (L + 1) idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
